// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue front end.
// Build option: ALU_ISSUE_OVF_EN enables the overflow (V) flag.
package alu_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 4;

    localparam logic [OP_W-1:0] OP_ADD        = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB        = 4'd1;
    localparam logic [OP_W-1:0] OP_NEG        = 4'd2;
    localparam logic [OP_W-1:0] OP_LOGIC_BASE = 4'd8;

    localparam int unsigned FLAG_C = 0;
    localparam int unsigned FLAG_Z = 1;
    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_V = 3;
    localparam int unsigned FLAG_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CLS_ARITH = 2'd0,
        CLS_NEG   = 2'd1,
        CLS_LOGIC = 2'd2,
        CLS_RSVD  = 2'd3
    } op_class_t;

    // Classify an opcode; the whole upper half of the code space is logic ops.
    function automatic op_class_t op_class(input logic [OP_W-1:0] op);
        op_class_t cls;
        if (op >= OP_LOGIC_BASE)               cls = CLS_LOGIC;
        else if (op == OP_ADD || op == OP_SUB) cls = CLS_ARITH;
        else if (op == OP_NEG)                 cls = CLS_NEG;
        else                                   cls = CLS_RSVD;
        return cls;
    endfunction

endpackage

// File: rtl/alu_flag_reg.sv
// Architectural flag register {V,N,Z,C}, updated once per executed op.
// Build option: ALU_ISSUE_OVF_EN adds the V flag; otherwise V stays 0.
module alu_flag_reg
    import alu_pkg::*;
#(
    parameter int unsigned W = DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_upd,
    input  op_class_t         i_cls,
    input  logic              i_carry,
    input  logic              i_zero,
    input  logic              i_msb,
    input  logic [W-1:0]      i_value,
`ifdef ALU_ISSUE_OVF_EN
    input  logic              i_ovf,
`endif
    output logic [FLAG_W-1:0] o_flags
);

    logic [FLAG_W-1:0] r_flags;
    logic [FLAG_W-1:0] w_flags_nxt;

    // NEG and logic ops take Z/N from the mux output, not the adder.
    always_comb begin
        w_flags_nxt = r_flags;
        case (i_cls)
            CLS_ARITH: begin
                w_flags_nxt[FLAG_C] = i_carry;
                w_flags_nxt[FLAG_Z] = i_zero;
                w_flags_nxt[FLAG_N] = i_msb;
`ifdef ALU_ISSUE_OVF_EN
                w_flags_nxt[FLAG_V] = i_ovf;
`endif
            end
            CLS_NEG: begin
                w_flags_nxt[FLAG_Z] = (i_value == '0);
                w_flags_nxt[FLAG_N] = i_value[W-1];
`ifdef ALU_ISSUE_OVF_EN
                w_flags_nxt[FLAG_V] = i_ovf;
`endif
            end
            CLS_LOGIC: begin
                w_flags_nxt[FLAG_Z] = (i_value == '0);
                w_flags_nxt[FLAG_N] = i_value[W-1];
            end
            default: ;
        endcase
`ifndef ALU_ISSUE_OVF_EN
        w_flags_nxt[FLAG_V] = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst)        r_flags <= '0;
        else if (i_upd) r_flags <= w_flags_nxt;
    end

    assign o_flags = r_flags;

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/response front end for the combinational 32-bit ALU.
// Build option: ALU_ISSUE_OVF_EN enables overflow detection into flags[3].
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned W   = DATA_W,
    parameter int unsigned OPW = OP_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [OPW-1:0]    req_op,
    input  logic [W-1:0]      req_a,
    input  logic [W-1:0]      req_b,
    output logic [W-1:0]      alu_x,
    output logic [W-1:0]      alu_y,
    output logic              alu_fn,
    output logic              alu_fnclass,
    output logic [2:0]        alu_logicfn,
    input  logic [W-1:0]      alu_value,
    input  logic              alu_carry,
    input  logic              alu_zero,
    input  logic              alu_msb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [W-1:0]      rsp_value,
    output logic              rsp_err,
    output logic [FLAG_W-1:0] flags
);

    state_t    r_state, w_state_nxt;
    logic      r_req_ready, w_req_ready_nxt;
    logic      r_rsp_valid, w_rsp_valid_nxt;
    op_class_t r_cls, w_cls;
    logic [W-1:0] r_x, r_y, w_x, w_y;
    logic      r_fn, w_fn, r_fnclass, w_fnclass;
    logic [2:0] r_logicfn, w_logicfn;
    logic [W-1:0] r_rsp_value;
    logic      r_rsp_err;
    logic      w_accept, w_exec;

    assign w_accept = req_valid && r_req_ready;
    assign w_exec   = (r_state == ST_EXEC);

    always_comb begin
        w_state_nxt     = r_state;
        w_req_ready_nxt = r_req_ready;
        w_rsp_valid_nxt = r_rsp_valid;
        case (r_state)
            ST_IDLE: if (w_accept) begin
                w_state_nxt     = ST_EXEC;
                w_req_ready_nxt = 1'b0;
            end
            ST_EXEC: begin
                w_state_nxt     = ST_HOLD;
                w_rsp_valid_nxt = 1'b1;
            end
            ST_HOLD: if (rsp_ready) begin
                w_state_nxt     = ST_IDLE;
                w_req_ready_nxt = 1'b1;
                w_rsp_valid_nxt = 1'b0;
            end
            default: begin
                w_state_nxt     = ST_IDLE;
                w_req_ready_nxt = 1'b1;
                w_rsp_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_req_ready <= w_req_ready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
        end
    end

    // ALU has no carry-in, so SUB negates b here before driving y.
    always_comb begin
        w_cls     = op_class(OP_W'(req_op));
        w_x       = '0;
        w_y       = '0;
        w_fn      = 1'b0;
        w_fnclass = 1'b0;
        w_logicfn = 3'd0;
        case (w_cls)
            CLS_ARITH: begin
                w_x = req_a;
                w_y = (req_op == OPW'(OP_SUB)) ? W'(~req_b + W'(1)) : req_b;
            end
            CLS_NEG: begin
                w_y  = req_b;
                w_fn = 1'b1;
            end
            CLS_LOGIC: begin
                w_x       = req_a;
                w_y       = req_b;
                w_fnclass = 1'b1;
                w_logicfn = req_op[2:0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cls     <= CLS_RSVD;
            r_x       <= '0;
            r_y       <= '0;
            r_fn      <= 1'b0;
            r_fnclass <= 1'b0;
            r_logicfn <= 3'd0;
        end else if (w_accept) begin
            r_cls     <= w_cls;
            r_x       <= w_x;
            r_y       <= w_y;
            r_fn      <= w_fn;
            r_fnclass <= w_fnclass;
            r_logicfn <= w_logicfn;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_value <= '0;
            r_rsp_err   <= 1'b0;
        end else if (w_exec) begin
            r_rsp_value <= (r_cls == CLS_RSVD) ? '0 : alu_value;
            r_rsp_err   <= (r_cls == CLS_RSVD);
        end
    end

`ifdef ALU_ISSUE_OVF_EN
    logic w_ovf;
    always_comb begin
        if (r_cls == CLS_NEG)
            w_ovf = (r_y == {1'b1, {(W-1){1'b0}}});
        else
            w_ovf = (r_x[W-1] == r_y[W-1]) && (alu_value[W-1] != r_x[W-1]);
    end
`endif

    alu_flag_reg #(.W(W)) u_flag_reg (
        .clk     (clk),
        .rst     (rst),
        .i_upd   (w_exec),
        .i_cls   (r_cls),
        .i_carry (alu_carry),
        .i_zero  (alu_zero),
        .i_msb   (alu_msb),
        .i_value (alu_value),
`ifdef ALU_ISSUE_OVF_EN
        .i_ovf   (w_ovf),
`endif
        .o_flags (flags)
    );

    assign req_ready   = r_req_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_value   = r_rsp_value;
    assign rsp_err     = r_rsp_err;
    assign alu_x       = r_x;
    assign alu_y       = r_y;
    assign alu_fn      = r_fn;
    assign alu_fnclass = r_fnclass;
    assign alu_logicfn = r_logicfn;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural model of the external ALU.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_a, req_b;
    logic [31:0] alu_x, alu_y, alu_value;
    logic        alu_fn, alu_fnclass;
    logic [2:0]  alu_logicfn;
    logic        alu_carry, alu_zero, alu_msb;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_value;
    logic [3:0]  flags;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] ex_x, ex_y;
    logic        ex_fn, ex_fnclass;
    logic [2:0]  ex_logicfn;

`ifdef ALU_ISSUE_OVF_EN
    localparam logic OVF = 1'b1;
`else
    localparam logic OVF = 1'b0;
`endif

    always #5 clk = ~clk;

    alu_issue_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .alu_x(alu_x), .alu_y(alu_y), .alu_fn(alu_fn),
        .alu_fnclass(alu_fnclass), .alu_logicfn(alu_logicfn),
        .alu_value(alu_value), .alu_carry(alu_carry),
        .alu_zero(alu_zero), .alu_msb(alu_msb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_value(rsp_value), .rsp_err(rsp_err), .flags(flags)
    );

    // External ALU: zero/msb come from the adder sum, value from the output mux.
    logic [32:0] m_sum;
    logic [31:0] m_logic;
    assign m_sum = {1'b0, alu_x} + {1'b0, alu_y};
    always_comb begin
        case (alu_logicfn)
            3'd0:    m_logic = alu_x & alu_y;
            3'd1:    m_logic = alu_x | alu_y;
            3'd2:    m_logic = alu_x ^ alu_y;
            default: m_logic = ~(alu_x & alu_y);
        endcase
    end
    assign alu_value = alu_fnclass ? m_logic : (alu_fn ? (32'd0 - m_sum[31:0]) : m_sum[31:0]);
    assign alu_carry = m_sum[32];
    assign alu_zero  = (m_sum[31:0] == 32'd0);
    assign alu_msb   = m_sum[31];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present one request, follow it through EXEC into HOLD.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int k = 0;
        while (!req_ready && k < 20) begin
            @(posedge clk); #1; k++;
        end
        check("issue_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("exec_rsp_valid", 32'(rsp_valid), 32'd0);
        check("exec_req_ready", 32'(req_ready), 32'd0);
        ex_x = alu_x; ex_y = alu_y; ex_fn = alu_fn;
        ex_fnclass = alu_fnclass; ex_logicfn = alu_logicfn;
        @(posedge clk); #1;
        check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
    endtask

    task automatic release_rsp();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("rel_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rel_req_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_op = 4'd0; req_a = 32'd0; req_b = 32'd0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_value", rsp_value, 32'd0);
        check("rst_rsp_err",   32'(rsp_err), 32'd0);
        check("rst_flags",     32'(flags), 32'd0);
        check("rst_alu_x",     alu_x, 32'd0);
        check("rst_alu_y",     alu_y, 32'd0);

        // ADD wrap to zero: C=1 Z=1
        issue(4'd0, 32'hFFFF_FFFF, 32'd1);
        check("add_fnclass", 32'(ex_fnclass), 32'd0);
        check("add_value", rsp_value, 32'd0);
        check("add_flags", 32'(flags), 32'h3);
        check("add_err", 32'(rsp_err), 32'd0);
        release_rsp();

        // NEG 5: Z/N from value, C kept from ADD
        issue(4'd2, 32'h1234_5678, 32'd5);
        check("neg_x", ex_x, 32'd0);
        check("neg_fn", 32'(ex_fn), 32'd1);
        check("neg_value", rsp_value, 32'hFFFF_FFFB);
        check("neg_flags", 32'(flags), 32'h5);
        release_rsp();

        // LOGIC op 9 (OR): C still 1
        issue(4'd9, 32'h0000_000F, 32'h8000_0000);
        check("logic_fnclass", 32'(ex_fnclass), 32'd1);
        check("logic_fn", 32'(ex_logicfn), 32'd1);
        check("logic_value", rsp_value, 32'h8000_000F);
        check("logic_flags", 32'(flags), 32'h5);
        release_rsp();

        // SUB 5-7, then stall in HOLD with a pending request
        issue(4'd1, 32'd5, 32'd7);
        check("sub_y", ex_y, 32'hFFFF_FFF9);
        check("sub_value", rsp_value, 32'hFFFF_FFFE);
        check("sub_flags", 32'(flags), 32'h4);
        req_valid = 1'b1; req_op = 4'd0; req_a = 32'd1; req_b = 32'd1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("stall_value", rsp_value, 32'hFFFF_FFFE);
            check("stall_req_ready", 32'(req_ready), 32'd0);
            check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0; req_valid = 1'b0;
        check("stall_rel_ready", 32'(req_ready), 32'd1);
        check("stall_rel_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        check("no_extra_accept", 32'(req_ready), 32'd1);

        // SUB of zero: y wraps to 0, C=0, Z=1
        issue(4'd1, 32'd0, 32'd0);
        check("sub0_y", ex_y, 32'd0);
        check("sub0_value", rsp_value, 32'd0);
        check("sub0_flags", 32'(flags), 32'h2);
        release_rsp();

        // Signed overflow on ADD
        issue(4'd0, 32'h7FFF_FFFF, 32'd1);
        check("ovf_value", rsp_value, 32'h8000_0000);
        check("ovf_flags", 32'(flags), {28'd0, OVF, 3'b100});
        release_rsp();

        // NEG of most-negative value
        issue(4'd2, 32'd0, 32'h8000_0000);
        check("negmin_value", rsp_value, 32'h8000_0000);
        check("negmin_flags", 32'(flags), {28'd0, OVF, 3'b100});
        release_rsp();

        // Reserved op: error, zero result, flags unchanged; then reset in HOLD
        issue(4'd4, 32'd1, 32'd2);
        check("rsvd_err", 32'(rsp_err), 32'd1);
        check("rsvd_value", rsp_value, 32'd0);
        check("rsvd_flags", 32'(flags), {28'd0, OVF, 3'b100});
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        check("abort_flags", 32'(flags), 32'd0);
        check("abort_req_ready", 32'(req_ready), 32'd1);
        check("abort_err", 32'(rsp_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
